sel_stream_gen: RTL and testbench

Selector-stream generator that sits directly upstream of the case/if decode stage and drives its selector input. On a start command it emits a programmed arithmetic sequence of selector values (base, base+step, …) over a valid/ready handshake, flags the final beat, and pulses completion. It owns all sequencing state, so the downstream decoder stays purely combinational on the selector.

---
 rtl/sel_stream_pkg.sv | 23 ++
 rtl/sel_stream_gen.sv | 154 +++++++++++++++
 tb/tb_sel_stream_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sel_stream_pkg.sv
// Shared types and helpers for the selector stream generator and its downstream decoder.
// Keeps state encoding and length clamping in one place so producer and consumer agree.
package sel_stream_pkg;

    localparam int SEL_WIDTH_DEF = 4;

    typedef logic [SEL_WIDTH_DEF-1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sel_state_t;

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
        if (len > max) begin
            return max;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/sel_stream_gen.sv
// Emits an arithmetic sequence of selector values over valid/ready, flags the final beat
// and pulses completion; every output comes straight from a flop.
module sel_stream_gen
    import sel_stream_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_LEN = 16,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_base,
    input  logic [WIDTH-1:0] i_step,
    input  logic [LW-1:0]    i_len,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_sel,
    output logic             o_sel_valid,
    input  logic             i_sel_ready,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [LW-1:0] LEN_ONE = LW'(32'd1);

    sel_state_t       state_r;
    sel_state_t       state_s;
    logic [LW-1:0]    cnt_r;
    logic [LW-1:0]    cnt_s;
    logic [LW-1:0]    len_r;
    logic [LW-1:0]    len_s;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] sel_r;
    logic [WIDTH-1:0] sel_s;
    logic             valid_r;
    logic             valid_s;
    logic             last_r;
    logic             last_s;
    logic             busy_r;
    logic             done_r;
    logic [LW-1:0]    clamp_s;
    logic             hs_s;

    assign clamp_s = LW'(clamp_len(32'(i_len), $unsigned(MAX_LEN)));
    assign hs_s    = valid_r & i_sel_ready;

    // Next-state, next-counter, next-selector and flag decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        step_s  = step_r;
        sel_s   = sel_r;
        valid_s = valid_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    len_s  = clamp_s;
                    step_s = i_step;
                    if (clamp_s == {LW{1'b0}}) begin
                        state_s = DONE;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                    end else begin
                        state_s = RUN;
                        sel_s   = i_base;
                        cnt_s   = {LW{1'b0}};
                        valid_s = 1'b1;
                        last_s  = (clamp_s == LEN_ONE);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Abort wins over a same-cycle handshake; that beat still counts as taken.
                if (i_abort) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end else if (hs_s) begin
                    if (cnt_r == (len_r - LEN_ONE)) begin
                        state_s = DONE;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                    end else begin
                        sel_s  = sel_r + step_r;
                        cnt_s  = cnt_r + LEN_ONE;
                        last_s = ((cnt_r + LEN_ONE) == (len_r - LEN_ONE));
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // Control state, latched command and registered status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            len_r   <= {LW{1'b0}};
            step_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            step_r  <= step_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Beat counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {LW{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

    // Selector accumulator
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_r <= {WIDTH{1'b0}};
        end else begin
            sel_r <= sel_s;
        end
    end

    assign o_sel       = sel_r;
    assign o_sel_valid = valid_r;
    assign o_last      = last_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

endmodule

// File: tb/tb_sel_stream_gen.sv
// Directed bench for sel_stream_gen: hand-computed selector sequences, handshake
// stalls, length edge cases, abort, ignored start and asynchronous reset.
module tb_sel_stream_gen;

    localparam int WIDTH   = 4;
    localparam int MAX_LEN = 16;
    localparam int LW      = 5;

    logic             i_clk       = 1'b0;
    logic             i_rst_n     = 1'b0;
    logic             i_start     = 1'b0;
    logic [WIDTH-1:0] i_base      = 4'd0;
    logic [WIDTH-1:0] i_step      = 4'd0;
    logic [LW-1:0]    i_len       = 5'd0;
    logic             i_abort     = 1'b0;
    logic             i_sel_ready = 1'b0;
    logic [WIDTH-1:0] o_sel;
    logic             o_sel_valid;
    logic             o_last;
    logic             o_busy;
    logic             o_done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];

    sel_stream_gen #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_step      (i_step),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .o_sel       (o_sel),
        .o_sel_valid (o_sel_valid),
        .i_sel_ready (i_sel_ready),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] b, input logic [3:0] s, input logic [4:0] l);
        i_base  = b;
        i_step  = s;
        i_len   = l;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Ready held high: expects exp_q beats back to back, then one done cycle.
    task automatic drain(input string tag, input int n);
        i_sel_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_valid"}, 32'(o_sel_valid), 32'd1);
            check_eq({tag, "_sel"}, 32'(o_sel), 32'(exp_q[k]));
            check_eq({tag, "_last"}, 32'(o_last), (k == n - 1) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq({tag, "_end_valid"}, 32'(o_sel_valid), 32'd0);
        check_eq({tag, "_done"}, 32'(o_done), 32'd1);
        check_eq({tag, "_done_busy"}, 32'(o_busy), 32'd1);
        tick();
        check_eq({tag, "_done_drop"}, 32'(o_done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    endtask

    int rdy_pat[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int delivered;

    initial begin
        // Reset state
        #12;
        check_eq("rst_sel", 32'(o_sel), 32'd0);
        check_eq("rst_valid", 32'(o_sel_valid), 32'd0);
        check_eq("rst_last", 32'(o_last), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Basic run 2,5,8,11
        exp_q = '{4'd2, 4'd5, 4'd8, 4'd11};
        issue(4'd2, 4'd3, 5'd4);
        check_eq("basic_busy", 32'(o_busy), 32'd1);
        drain("basic", 4);

        // Wrap 14,15,0
        exp_q = '{4'd14, 4'd15, 4'd0};
        issue(4'd14, 4'd1, 5'd3);
        drain("wrap", 3);

        // Over-length request clamps to 16 beats 0..15
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        issue(4'd0, 4'd1, 5'd20);
        drain("clamp", 16);

        // Zero length: done next cycle, no beats
        i_sel_ready = 1'b1;
        issue(4'd5, 4'd1, 5'd0);
        check_eq("zero_valid", 32'(o_sel_valid), 32'd0);
        check_eq("zero_done", 32'(o_done), 32'd1);
        check_eq("zero_busy", 32'(o_busy), 32'd1);
        tick();
        check_eq("zero_done_drop", 32'(o_done), 32'd0);
        check_eq("zero_idle", 32'(o_busy), 32'd0);

        // Backpressure: ready 1,0,0,1,... over beats 1,3,5
        exp_q = '{4'd1, 4'd3, 4'd5};
        i_sel_ready = 1'b0;
        issue(4'd1, 4'd2, 5'd3);
        delivered = 0;
        for (int c = 0; c < 12 && delivered < 3; c++) begin
            i_sel_ready = rdy_pat[c][0];
            check_eq("bp_valid", 32'(o_sel_valid), 32'd1);
            check_eq("bp_sel", 32'(o_sel), 32'(exp_q[delivered]));
            check_eq("bp_last", 32'(o_last), (delivered == 2) ? 32'd1 : 32'd0);
            tick();
            if (rdy_pat[c] != 0) delivered++;
        end
        i_sel_ready = 1'b0;
        check_eq("bp_count", 32'(delivered), 32'd3);
        check_eq("bp_end_valid", 32'(o_sel_valid), 32'd0);
        check_eq("bp_done", 32'(o_done), 32'd1);
        tick();
        check_eq("bp_idle", 32'(o_busy), 32'd0);

        // Abort on beat 2 of 5
        i_sel_ready = 1'b1;
        issue(4'd0, 4'd1, 5'd5);
        check_eq("abort_b0", 32'(o_sel), 32'd0);
        tick();
        check_eq("abort_b1", 32'(o_sel), 32'd1);
        tick();
        check_eq("abort_b2", 32'(o_sel), 32'd2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_eq("abort_valid", 32'(o_sel_valid), 32'd0);
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_done", 32'(o_done), 32'd0);
        tick();
        check_eq("abort_done_later", 32'(o_done), 32'd0);
        check_eq("abort_stay_idle", 32'(o_sel_valid), 32'd0);

        // Start while busy is ignored: 3,7,11 continues unchanged
        issue(4'd3, 4'd4, 5'd3);
        check_eq("ign_b0", 32'(o_sel), 32'd3);
        i_base  = 4'd9;
        i_step  = 4'd1;
        i_len   = 5'd2;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check_eq("ign_b1", 32'(o_sel), 32'd7);
        check_eq("ign_b1_last", 32'(o_last), 32'd0);
        tick();
        check_eq("ign_b2", 32'(o_sel), 32'd11);
        check_eq("ign_b2_last", 32'(o_last), 32'd1);
        tick();
        check_eq("ign_done", 32'(o_done), 32'd1);
        tick();
        check_eq("ign_idle", 32'(o_busy), 32'd0);

        // Asynchronous reset mid-run
        issue(4'd6, 4'd1, 5'd4);
        tick();
        check_eq("arst_pre_sel", 32'(o_sel), 32'd7);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("arst_sel", 32'(o_sel), 32'd0);
        check_eq("arst_valid", 32'(o_sel_valid), 32'd0);
        check_eq("arst_last", 32'(o_last), 32'd0);
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_done", 32'(o_done), 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        check_eq("arst_wait_valid", 32'(o_sel_valid), 32'd0);
        check_eq("arst_wait_done", 32'(o_done), 32'd0);
        exp_q = '{4'd6, 4'd7};
        issue(4'd6, 4'd1, 5'd2);
        drain("arst_rerun", 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
